// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch display path.
//   digit_sel_t   : 2-bit scan slot index (0 = deciseconds .. 3 = minutes)
//   SEG_*         : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   AN_OFF        : all four common-anode drivers released
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    typedef logic [1:0] digit_sel_t;

    localparam digit_sel_t SEL_DSEC  = 2'd0;
    localparam digit_sel_t SEL_SEC_R = 2'd1;
    localparam digit_sel_t SEL_SEC_L = 2'd2;
    localparam digit_sel_t SEL_MIN   = 2'd3;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    // Anode pattern enabling exactly one digit (active-low).
    function automatic logic [3:0] an_for(input digit_sel_t sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
// Combinational BCD to seven-segment decoder, active-low outputs.
//   bcd : 4-bit digit; codes 10-15 are not BCD and render as a dash
//   seg : {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module bcd_to_seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here via
        // the default arm); a missing assignment would infer a latch.
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_seg_mux.sv
// ---------------------------------------------------------------------------
// stopwatch_seg_mux
// Scans the four stopwatch BCD digits onto a common-anode 4-digit display,
// format "M.SS.d". Digits are snapshotted once per frame so a frame never
// mixes old and new values, and each slot opens with a short all-off
// interval to suppress ghosting while the segment lines settle.
//   clk        : system clock, rising edge
//   clr        : asynchronous active-low reset
//   Decisecond, Second_R, Second_L, Minutes : BCD digits, same clock domain
//   an         : anodes, active-low, an[0]=Decisecond .. an[3]=Minutes
//   seg        : segments {g..a}, active-low
//   dp         : decimal point, active-low
// Outputs are registered: they reflect the scan state of the previous cycle.
// ---------------------------------------------------------------------------
module stopwatch_seg_mux
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
)
(
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] Decisecond,
    input  logic [3:0] Second_R,
    input  logic [3:0] Second_L,
    input  logic [3:0] Minutes,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    digit_sel_t       sel_q,   sel_d;
    logic [3:0][3:0]  frame_q, frame_d;  // [sel] -> digit shown in that slot
    logic [3:0]       an_q,    an_d;
    logic [6:0]       seg_q,   seg_d;
    logic             dp_q,    dp_d;

    logic             tick;
    logic [3:0]       cur_digit;
    logic [6:0]       cur_seg;

    bcd_to_seg u_dec (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    always_comb begin
        tick      = (cnt_q == CNT_LAST);
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        sel_d     = tick ? digit_sel_t'(sel_q + 2'd1) : sel_q;

        // Load the next frame on the edge that leaves the minutes slot, so
        // the new values take effect exactly as slot 0 begins.
        frame_d   = frame_q;
        if (tick && (sel_q == SEL_MIN)) begin
            frame_d = {Minutes, Second_L, Second_R, Decisecond};
        end

        cur_digit = frame_q[sel_q];
        an_d      = (cnt_q < CNT_BLANK) ? AN_OFF : an_for(sel_q);
        // Segment lines keep the current digit even while blanked.
        seg_d     = cur_seg;
        // Points follow the minutes digit and the seconds units digit
        // (slots 3 and 1), i.e. whenever the slot index is odd.
        dp_d      = ~sel_q[0];
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent behaviour.
    // NOTE: the frame buffer is reset as well, because the display must read
    // "0.00.0" until the first snapshot rather than showing power-up garbage.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q   <= '0;
            sel_q   <= SEL_DSEC;
            frame_q <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_seg_mux.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_seg_mux
// Directed bench for stopwatch_seg_mux with REFRESH_DIV=8, BLANK_CYCLES=2.
// A frame is 32 cycles; the outputs sampled after the k-th clock edge since
// reset release reflect scan state k-1 (one-cycle output register).
// ---------------------------------------------------------------------------
module tb_stopwatch_seg_mux;

    localparam int REFRESH_DIV  = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 4 * REFRESH_DIV;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] Decisecond = 4'd0;
    logic [3:0] Second_R   = 4'd0;
    logic [3:0] Second_L   = 4'd0;
    logic [3:0] Minutes    = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp = 0;
    int n_err = 0;

    stopwatch_seg_mux #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .Decisecond (Decisecond),
        .Second_R   (Second_R),
        .Second_L   (Second_L),
        .Minutes    (Minutes),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Segment table written out from the display datasheet patterns.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Advance one clock and sample away from the rising edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Step through n_cyc scan states of one frame starting at slot 0, cnt 0,
    // checking every output each cycle against the digits expected on screen.
    // After the check at local cycle chg_at, drive input chg_which to chg_val.
    task automatic run_frame(input string name,
                             input logic [3:0] d_dsec, input logic [3:0] d_secr,
                             input logic [3:0] d_secl, input logic [3:0] d_min,
                             input int n_cyc, input int chg_at,
                             input int chg_which, input logic [3:0] chg_val);
        logic [3:0] digs [4];
        logic [3:0] exp_an;
        int         sel;
        int         cnt;
        digs[0] = d_dsec;
        digs[1] = d_secr;
        digs[2] = d_secl;
        digs[3] = d_min;
        for (int j = 0; j < n_cyc; j++) begin
            step();
            sel    = j / REFRESH_DIV;
            cnt    = j % REFRESH_DIV;
            exp_an = (cnt < BLANK_CYCLES) ? 4'b1111 : ~(4'b0001 << sel);
            check($sformatf("%s j%0d an", name, j), 32'(an), 32'(exp_an));
            check($sformatf("%s j%0d seg", name, j), 32'(seg), 32'(seg_of(digs[sel])));
            check($sformatf("%s j%0d dp", name, j), 32'(dp),
                  32'((sel == 1 || sel == 3) ? 1'b0 : 1'b1));
            if (j == chg_at) begin
                case (chg_which)
                    0: Decisecond = chg_val;
                    1: Second_R   = chg_val;
                    2: Second_L   = chg_val;
                    default: Minutes = chg_val;
                endcase
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " an"},  32'(an),  32'h0000000F);
        check({name, " seg"}, 32'(seg), 32'h0000007F);
        check({name, " dp"},  32'(dp),  32'h00000001);
    endtask

    initial begin
        // Reset with arbitrary live inputs.
        Minutes = 4'd5; Second_L = 4'd9; Second_R = 4'd3; Decisecond = 4'd7;
        #2 clr = 1'b0;
        #1 check_reset_outputs("rst async");
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_outputs($sformatf("rst hold%0d", i));
        end

        // Release on a falling edge; frame 0 shows the reset buffer "0.00.0"
        // (blank for cycles 1-2, then an=1110 with seg '0').
        clr = 1'b1;
        run_frame("f0 zero", 4'd0, 4'd0, 4'd0, 4'd0, FRAME, -1, 0, 4'd0);

        // Frame 1: scan order 7,3,9,5. At slot 2 (cnt 3) Second_R goes 3->4;
        // the rest of this frame must still show 3.
        run_frame("f1 scan", 4'd7, 4'd3, 4'd9, 4'd5, FRAME, 19, 1, 4'd4);

        // Frame 2: new Second_R visible; Decisecond becomes invalid mid-frame.
        run_frame("f2 tear", 4'd7, 4'd4, 4'd9, 4'd5, FRAME, 10, 0, 4'hC);

        // Frame 3: invalid digit shows as a dash; stop while sel==2, cnt==5.
        run_frame("f3 dash", 4'hC, 4'd4, 4'd9, 4'd5, 21, -1, 0, 4'd0);

        // Mid-frame reset: outputs drop immediately and stay off.
        clr = 1'b0;
        #1 check_reset_outputs("mid rst async");
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_outputs($sformatf("mid rst hold%0d", i));
        end
        clr = 1'b1;

        // Scan restarts at slot 0 with a cleared buffer, then the live
        // inputs return at the next frame.
        run_frame("f4 zero", 4'd0, 4'd0, 4'd0, 4'd0, FRAME, -1, 0, 4'd0);
        run_frame("f5 back", 4'hC, 4'd4, 4'd9, 4'd5, FRAME, -1, 0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
